// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan multiplexer: scan states,
// the dark-segment constant and the active-low hex glyph table.
package seg_pkg;

    typedef enum logic {
        ST_ON  = 1'b0,
        ST_GAP = 1'b1
    } scan_state_t;

    localparam logic [6:0] SEG_OFF = 7'b1111111;

    // Active-low segments, bit 6 = a ... bit 0 = g; entry 0 is glyph '0'.
    localparam logic [0:15][6:0] HEX_GLYPH = {
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/seg_scan_mux_if.sv
// Display bus: digit data and load strobe in, registered anode/cathode drive out.
interface seg_scan_mux_if #(parameter int NUM_DIGITS = 4);

    logic                      load;
    logic [4*NUM_DIGITS-1:0]   digits;
    logic [NUM_DIGITS-1:0]     blank;
    logic [NUM_DIGITS-1:0]     dp;
    logic [NUM_DIGITS-1:0]     anode;
    logic [6:0]                cathode;
    logic                      dp_n;
    logic                      frame_done;

    modport master (
        output load, digits, blank, dp,
        input  anode, cathode, dp_n, frame_done
    );

    modport slave (
        input  load, digits, blank, dp,
        output anode, cathode, dp_n, frame_done
    );

endinterface

// File: rtl/seg_hex_decoder.sv
// Combinational nibble to active-low seven-segment glyph lookup.
module seg_hex_decoder
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = HEX_GLYPH[nibble];

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed seven-segment driver: ON/GAP slot scan with frame-atomic data update.
// All outputs registered; new data lands at the frame wrap, never mid-frame.
module seg_scan_mux
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DIV        = 100000,
    parameter int GAP        = 16
)(
    input  logic           clock,
    input  logic           reset,
    seg_scan_mux_if.slave  bus
);

    localparam int CW = $clog2(max3(DIV, GAP, 2));
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int DW = 4 * NUM_DIGITS;

    localparam logic [CW-1:0] ON_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    scan_state_t              state, nxt_state;
    logic [IW-1:0]            idx, nxt_idx;
    logic [CW-1:0]            cnt, nxt_cnt;
    logic                     run;
    logic                     slot_end;
    logic                     wrap;

    logic [DW-1:0]            pend_dig, shad_dig, nxt_dig;
    logic [NUM_DIGITS-1:0]    pend_blank, shad_blank, nxt_blank;
    logic [NUM_DIGITS-1:0]    pend_dp, shad_dp, nxt_dp;
    logic                     pend_vld;

    logic [3:0]               cur_nibble;
    logic [6:0]               cur_glyph;
    logic                     dark;

    // First cycle after reset holds ON/idx0/cnt0 so slot 0 gets its full DIV cycles.
    always_comb begin
        nxt_state = state;
        nxt_idx   = idx;
        nxt_cnt   = cnt;
        slot_end  = 1'b0;
        if (run) begin
            if (state == ST_ON) begin
                if (cnt == ON_LAST) begin
                    nxt_cnt = '0;
                    if (GAP > 0) nxt_state = ST_GAP;
                    else         slot_end  = 1'b1;
                end else begin
                    nxt_cnt = cnt + CW'(1);
                end
            end else begin
                if (cnt == GAP_LAST) begin
                    nxt_cnt   = '0;
                    nxt_state = ST_ON;
                    slot_end  = 1'b1;
                end else begin
                    nxt_cnt = cnt + CW'(1);
                end
            end
            if (slot_end) nxt_idx = (idx == IDX_LAST) ? '0 : idx + IW'(1);
        end
    end

    assign wrap = slot_end && (idx == IDX_LAST);

    // A load on the wrap edge bypasses pending so it shows in slot 0 of the new frame.
    always_comb begin
        nxt_dig   = shad_dig;
        nxt_blank = shad_blank;
        nxt_dp    = shad_dp;
        if (wrap) begin
            if (bus.load) begin
                nxt_dig   = bus.digits;
                nxt_blank = bus.blank;
                nxt_dp    = bus.dp;
            end else if (pend_vld) begin
                nxt_dig   = pend_dig;
                nxt_blank = pend_blank;
                nxt_dp    = pend_dp;
            end
        end
    end

    assign cur_nibble = nxt_dig[4*nxt_idx +: 4];
    assign dark       = (nxt_state == ST_GAP) || nxt_blank[nxt_idx];

    seg_hex_decoder u_dec (
        .nibble (cur_nibble),
        .seg    (cur_glyph)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= ST_ON;
            idx            <= '0;
            cnt            <= '0;
            run            <= 1'b0;
            pend_vld       <= 1'b0;
            pend_dig       <= '0;
            pend_blank     <= '1;
            pend_dp        <= '0;
            shad_dig       <= '0;
            shad_blank     <= '1;
            shad_dp        <= '0;
            bus.anode      <= '1;
            bus.cathode    <= SEG_OFF;
            bus.dp_n       <= 1'b1;
            bus.frame_done <= 1'b0;
        end else begin
            state      <= nxt_state;
            idx        <= nxt_idx;
            cnt        <= nxt_cnt;
            run        <= 1'b1;
            shad_dig   <= nxt_dig;
            shad_blank <= nxt_blank;
            shad_dp    <= nxt_dp;
            if (wrap) begin
                pend_vld <= 1'b0;
            end else if (bus.load) begin
                pend_dig   <= bus.digits;
                pend_blank <= bus.blank;
                pend_dp    <= bus.dp;
                pend_vld   <= 1'b1;
            end
            bus.anode      <= (nxt_state == ST_ON) ? ~(NUM_DIGITS'(1) << nxt_idx) : '1;
            bus.cathode    <= dark ? SEG_OFF : cur_glyph;
            bus.dp_n       <= dark | ~nxt_dp[nxt_idx];
            bus.frame_done <= wrap;
        end
    end

endmodule

// File: doc/seg_scan_mux.md
SEG_SCAN_MUX -- requirements
Module: seg_scan_mux

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits (range 2..8).
REQ-002 SHALL have parameter DIV, default 100000, clock cycles each digit is lit per scan slot (DIV >= 1).
REQ-003 SHALL have parameter GAP, default 16, all-dark cycles between slots for anti-ghosting (GAP >= 0; 0 means no gap).
REQ-004 SHALL have port clock  in  1  system clock, rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high.
REQ-006 SHALL have port load  in  1  one-cycle strobe that captures digits/blank/dp.
REQ-007 SHALL have port digits  in  4*NUM_DIGITS  hex nibbles; nibble k drives digit k (k=0 is rightmost).
REQ-008 SHALL have port blank  in  NUM_DIGITS  1 = digit k dark in its slot.
REQ-009 SHALL have port dp  in  NUM_DIGITS  1 = decimal point of digit k lit.
REQ-010 SHALL have port anode  out  NUM_DIGITS  active-low digit enables.
REQ-011 SHALL have port cathode  out  7  active-low segments; bit 6 = a ... bit 0 = g.
REQ-012 SHALL have port dp_n  out  1  active-low decimal point.
REQ-013 SHALL have port frame_done  out  1  one-cycle pulse at each frame wrap.

Function
REQ-014 SHALL scan with states ON and GAP; ON lasts DIV cycles with only anode[idx] low; GAP lasts GAP cycles with all anodes high; when GAP=0 the GAP state is skipped.
REQ-015 SHALL advance idx at the end of each slot; idx wraps from NUM_DIGITS-1 to 0; slot = DIV+GAP cycles, frame = NUM_DIGITS*(DIV+GAP) cycles.
REQ-016 SHALL register anode, cathode and dp_n, updating them on the same edge as the state/idx change they reflect; no combinational path from any input to any output.
REQ-017 SHALL decode nibbles 0-F to standard hex glyphs, active-low (e.g. 0=0000001, 1=1001111, 2=0010010, A=0001000, F=0111000).
REQ-018 SHALL drive cathode=1111111 and dp_n=1 during GAP and when blank[idx]=1 in the shadow copy.
REQ-019 SHALL capture digits/blank/dp into a pending register on load and set a pending flag; a later load before the wrap overwrites the pending data (last load wins).
REQ-020 SHALL copy pending into the displayed shadow register only at the frame-wrap edge (idx N-1 -> 0), then clear the flag; a frame is never shown with mixed data.
REQ-021 SHALL, when load coincides with the wrap edge, copy the newly loaded values into the shadow directly at that edge and leave the flag clear.
REQ-022 SHALL assert frame_done for exactly the one cycle following the wrap edge.
REQ-023 SHALL size the prescale counter as $clog2(max(DIV,GAP,2)) bits; counter counts 0..DIV-1 or 0..GAP-1 and never overflows.

Reset
REQ-024 SHALL, while reset is high, force anode all 1, cathode 1111111, dp_n 1, frame_done 0, state ON, idx 0, counter 0, pending flag 0.
REQ-025 SHALL reset shadow and pending: digits 0, dp 0, blank all 1, so the display stays dark until the first loaded data reaches the shadow.
REQ-026 SHALL, on the first edge with reset low, enter ON for idx 0 (anode[0] low); reset mid-frame discards pending data and restarts the scan.

Structure
REQ-027 SHALL place the ON/GAP state enum, the SEG_OFF constant (7'b1111111) and the 16-entry hex glyph table in shared package seg_pkg.
REQ-028 SHALL implement the nibble-to-glyph decode as combinational sub-module seg_hex_decoder (4-bit in, 7-bit active-low out).

Verification (NUM_DIGITS=4, DIV=4, GAP=1 unless noted)
REQ-029 SHALL cover reset release: anode sequence 1110 x4, 1111 x1, 1101 x4, 1111 x1, ...; cathode 1111111 throughout; frame_done pulses every 20 cycles.
REQ-030 SHALL cover load digits=16'h21A0, blank=0, dp=4'b0100: after the next wrap, slot0 shows 0000001, slot1 0001000, slot2 1001111 with dp_n=0, slot3 0010010.
REQ-031 SHALL cover mid-frame loads of 16'h1111 then 16'h2222: the current frame is unchanged, and the next frame shows 0010010 on all digits.
REQ-032 SHALL cover load on the wrap edge: the new data appears in slot0 of that same frame.
REQ-033 SHALL cover blank=4'b1010: digits 1 and 3 are dark while their anodes are still scanned; GAP=0 run: no all-high anode cycles, frame = 16 cycles.
REQ-034 SHALL cover reset asserted during slot2 with pending data: outputs dark next cycle; after release the display is dark (blank reset) and the discarded data never appears.
